// File: rtl/write_buffer_id_alloc.sv
// Write-buffer slot ID allocator: keeps the free list of wbuf slot IDs, grants
// one slot per accepted upstream write, issues the enqueue into write_buffer and
// reclaims slots when write_buffer returns them.

package write_buffer_id_alloc_pkg;
    typedef struct packed {
        int unsigned wbufSize;
    } mpc_u_t;

    typedef struct packed {
        mpc_u_t      u;
        int unsigned wbufWidth;
    } mpc_cfg_t;
endpackage

module write_buffer_id_alloc #(
    parameter write_buffer_id_alloc_pkg::mpc_cfg_t Cfg = '{u: '{wbufSize: 32'd4}, wbufWidth: 32'd3},
    parameter type wbufWidth_t = logic [Cfg.wbufWidth-1:0],
    parameter type wbuf_req_t  = logic [Cfg.wbufWidth+127:0]
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_req_valid,
    output logic         wr_req_ready,
    input  logic [127:0] wr_req_wdata,
    output wbufWidth_t   wr_alloc_id,
    output logic         xbar_req_valid,
    output wbuf_req_t    xbar_req,
    input  logic         xbar_rsp_free_valid,
    input  wbufWidth_t   xbar_rsp_free_id,
    output logic [Cfg.wbufWidth:0] free_cnt,
    output logic         err_bad_free
);
    localparam int N  = int'(Cfg.u.wbufSize);
    localparam int W  = int'(Cfg.wbufWidth);
    localparam int PW = $clog2(N);
    localparam logic [W:0]    N_V   = (W+1)'(N);
    localparam logic [PW-1:0] LAST  = PW'(N - 1);

    logic [W-1:0]        fifo [N];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    // Sized to the full ID space so any returned ID indexes it directly;
    // entries at or above N are never set.
    logic [(1<<W)-1:0]   bitmap;

    logic accept;
    logic ret_in_range;
    logic ret_ok;
    logic ret_bad;

    assign wr_req_ready = (free_cnt != '0);
    assign wr_alloc_id  = wbufWidth_t'(fifo[head]);
    assign accept       = wr_req_valid & wr_req_ready;

    // A return is only legal for an in-range ID that is outstanding in the
    // registered bitmap; this also rejects returning the ID granted this cycle.
    assign ret_in_range = ({1'b0, W'(xbar_rsp_free_id)} < N_V);
    assign ret_ok       = xbar_rsp_free_valid & ret_in_range & bitmap[W'(xbar_rsp_free_id)];
    assign ret_bad      = xbar_rsp_free_valid & ~ret_ok;

    // Free list, pointers, outstanding bitmap and free counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) fifo[i] <= W'(i);
            head     <= '0;
            tail     <= '0;
            bitmap   <= '0;
            free_cnt <= N_V;
        end else begin
            if (accept) begin
                head                <= (head == LAST) ? '0 : head + 1'b1;
                bitmap[fifo[head]]  <= 1'b1;
            end
            if (ret_ok) begin
                fifo[tail]                      <= W'(xbar_rsp_free_id);
                tail                            <= (tail == LAST) ? '0 : tail + 1'b1;
                bitmap[W'(xbar_rsp_free_id)]    <= 1'b0;
            end
            free_cnt <= free_cnt + {{W{1'b0}}, ret_ok} - {{W{1'b0}}, accept};
        end
    end

    // Enqueue one cycle after accept; payload holds its last value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xbar_req_valid <= 1'b0;
            xbar_req       <= '0;
        end else begin
            xbar_req_valid <= accept;
            if (accept) xbar_req <= wbuf_req_t'({fifo[head], wr_req_wdata});
        end
    end

    // One-cycle error pulse for a dropped return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_bad_free <= 1'b0;
        else        err_bad_free <= ret_bad;
    end

endmodule

// File: tb/tb_write_buffer_id_alloc.sv
// Directed bench for write_buffer_id_alloc (N=4, 3-bit IDs). Stimulus pushes the
// hand-derived enqueue payloads and error-pulse cycles into queues; a negedge
// monitor pops and compares whenever the DUT presents them.

module tb_write_buffer_id_alloc;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_req_valid = 1'b0;
    logic         wr_req_ready;
    logic [127:0] wr_req_wdata = '0;
    logic [W-1:0] wr_alloc_id;
    logic         xbar_req_valid;
    logic [W+127:0] xbar_req;
    logic         xbar_rsp_free_valid = 1'b0;
    logic [W-1:0] xbar_rsp_free_id = '0;
    logic [W:0]   free_cnt;
    logic         err_bad_free;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    logic [W+127:0] exp_q [$];
    int             err_q [$];

    write_buffer_id_alloc #(
        .Cfg('{u: '{wbufSize: 32'd4}, wbufWidth: 32'd3})
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_req_valid        (wr_req_valid),
        .wr_req_ready        (wr_req_ready),
        .wr_req_wdata        (wr_req_wdata),
        .wr_alloc_id         (wr_alloc_id),
        .xbar_req_valid      (xbar_req_valid),
        .xbar_req            (xbar_req),
        .xbar_rsp_free_valid (xbar_rsp_free_valid),
        .xbar_rsp_free_id    (xbar_rsp_free_id),
        .free_cnt            (free_cnt),
        .err_bad_free        (err_bad_free)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [W+127:0] act, input logic [W+127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] wd(input int i);
        return {4{32'hA5000000 + 32'(i)}};
    endfunction

    // Monitor: every enqueue pulse and error pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (xbar_req_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL xbar_req_unexpected: got %0h expected no pulse", xbar_req);
                end else begin
                    chk("xbar_req", xbar_req, exp_q.pop_front());
                end
            end
            if (err_bad_free) begin
                if (err_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL err_unexpected: got pulse at cycle %0d expected none", cycle);
                end else begin
                    chk("err_cycle", (W+128)'(cycle), (W+128)'(err_q.pop_front()));
                end
            end
        end
    end

    // One cycle of stimulus starting at posedge+1; ends at the next posedge+1.
    task automatic issue(input bit v, input int wi, input bit acc, input int eid,
                         input bit f, input int fid, input bit ebad);
        wr_req_valid        = v;
        wr_req_wdata        = wd(wi);
        xbar_rsp_free_valid = f;
        xbar_rsp_free_id    = W'(fid);
        if (acc)  exp_q.push_back({W'(eid), wd(wi)});
        if (ebad) err_q.push_back(cycle + 1);
        @(posedge clk); #1;
        wr_req_valid        = 1'b0;
        xbar_rsp_free_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state();
        chk("rst_ready",  (W+128)'(wr_req_ready),   (W+128)'(1));
        chk("rst_cnt",    (W+128)'(free_cnt),       (W+128)'(4));
        chk("rst_alloc",  (W+128)'(wr_alloc_id),    (W+128)'(0));
        chk("rst_xvalid", (W+128)'(xbar_req_valid), (W+128)'(0));
        chk("rst_xreq",   xbar_req,                 '0);
        chk("rst_err",    (W+128)'(err_bad_free),   (W+128)'(0));
    endtask

    task automatic chk_cnt(input string name, input int exp);
        chk(name, (W+128)'(free_cnt), (W+128)'(exp));
    endtask

    task automatic chk_alloc(input string name, input int exp);
        chk(name, (W+128)'(wr_alloc_id), (W+128)'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        idle(1);
        do_reset();
        chk_reset_state();

        // Four back-to-back grants 0..3, then empty.
        for (int i = 0; i < 4; i++) begin
            chk_alloc("alloc_seq", i);
            issue(1, i, 1, i, 0, 0, 0);
        end
        chk_cnt("empty_cnt", 0);
        chk("empty_ready", (W+128)'(wr_req_ready), (W+128)'(0));

        // Request held off while empty: no enqueue may appear.
        issue(1, 9, 0, 0, 0, 0, 0);
        chk_cnt("held_cnt", 0);

        // Return 2 from empty; it becomes the next grant.
        issue(0, 0, 0, 0, 1, 2, 0);
        chk("ret2_ready", (W+128)'(wr_req_ready), (W+128)'(1));
        chk_alloc("ret2_alloc", 2);
        chk_cnt("ret2_cnt", 1);
        issue(1, 10, 1, 2, 0, 0, 0);
        chk_cnt("ret2_acc_cnt", 0);

        // Return 0, then accept 0 while returning 1 in the same cycle.
        issue(0, 0, 0, 0, 1, 0, 0);
        chk_alloc("ret0_alloc", 0);
        issue(1, 11, 1, 0, 1, 1, 0);
        chk_cnt("same_cyc_cnt", 1);
        chk_alloc("same_cyc_alloc", 1);

        // Return 3 twice: second is a bad free.
        issue(0, 0, 0, 0, 1, 3, 0);
        chk_cnt("ret3_cnt", 2);
        issue(0, 0, 0, 0, 1, 3, 1);
        chk_cnt("ret3_dup_cnt", 2);

        // Returning the ID being granted this cycle is a bad free.
        chk_alloc("pre_self_alloc", 1);
        issue(1, 12, 1, 1, 1, 1, 1);
        chk_cnt("self_ret_cnt", 1);
        chk_alloc("self_ret_alloc", 3);
        idle(2);

        // All free: any return and an out-of-range ID are bad frees.
        do_reset();
        chk_reset_state();
        issue(0, 0, 0, 0, 1, 0, 1);
        issue(0, 0, 0, 0, 1, 5, 1);
        chk_cnt("bad_full_cnt", 4);

        // Three grants outstanding, then reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            chk_alloc("pre_rst_alloc", i);
            issue(1, 20 + i, 1, i, 0, 0, 0);
        end
        chk_cnt("pre_rst_cnt", 1);
        idle(1);
        do_reset();
        chk_reset_state();
        for (int i = 0; i < 4; i++) begin
            chk_alloc("post_rst_alloc", i);
            issue(1, 30 + i, 1, i, 0, 0, 0);
        end
        chk_cnt("post_rst_cnt", 0);

        idle(3);
        chk("exp_q_drained", (W+128)'(exp_q.size()), '0);
        chk("err_q_drained", (W+128)'(err_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
